// File: rtl/byte_ser_pkg.sv
// Shared types and defaults for the byte FIFO serializer and its prefetch stage.
package byte_ser_pkg;

  typedef enum logic [1:0] {
    P_IDLE,
    P_SETTLE,
    P_FULL
  } pf_state_t;

  // Which kind of byte currently occupies the shift register (sync insertion build).
  typedef enum logic [1:0] {
    S_SYNC_HI,
    S_SYNC_LO,
    S_DATA
  } sync_phase_t;

  localparam int          BYTE_W        = 8;
  localparam int          BIT_CNT_W     = 3;
  localparam logic [7:0]  FILL_BYTE_DEF = 8'h55;
  localparam logic [15:0] SYNC_WORD_DEF = 16'hEB90;

endpackage

// File: rtl/byte_fifo_prefetch.sv
// Prefetch stage: pops one byte from the registered-output FIFO into a holding
// register, waiting one clkEn after leaving idle so fifoDout reflects the head.
module byte_fifo_prefetch
  import byte_ser_pkg::*;
#(
  parameter int DATA_W = BYTE_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clkEn,
  input  logic              enable,
  input  logic              take,
  output logic              holdValid,
  output logic [DATA_W-1:0] holdByte,
  input  logic [DATA_W-1:0] fifoDout,
  input  logic              fifoEmpty,
  output logic              fifoRdEn
);

  pf_state_t state, stateNxt;
  logic      capture;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= P_IDLE;
    end else if (clkEn) begin
      state <= stateNxt;
    end
  end

  always_comb begin
    stateNxt = state;
    capture  = 1'b0;
    case (state)
      P_IDLE: begin
        if (enable && !fifoEmpty) stateNxt = P_SETTLE;
      end
      P_SETTLE: begin
        if (fifoEmpty) begin
          stateNxt = P_IDLE;
        end else if (enable) begin
          capture  = 1'b1;
          stateNxt = P_FULL;
        end
      end
      P_FULL: begin
        if (take) stateNxt = P_IDLE;
      end
      default: stateNxt = P_IDLE;
    endcase
  end

  // The pop and the capture share one qualified strobe so they can never diverge.
  assign fifoRdEn  = capture & clkEn & ~reset;
  assign holdValid = (state == P_FULL);

  always_ff @(posedge clk) begin
    if (fifoRdEn) holdByte <= fifoDout;
  end

endmodule

// File: rtl/byte_fifo_serializer.sv
// Byte FIFO to MSB-first serial bitstream with fill-byte substitution on underrun.
// Optional feature: define SER_SYNC_INSERT_EN to prefix every FRAME_BYTES bytes with SYNC_WORD.
module byte_fifo_serializer
  import byte_ser_pkg::*;
#(
  parameter logic [7:0]  FILL_BYTE   = FILL_BYTE_DEF,
  parameter int          FRAME_BYTES = 64,
  parameter logic [15:0] SYNC_WORD   = SYNC_WORD_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clkEn,
  input  logic        enable,
  input  logic        bitEn,
  input  logic [7:0]  fifoDout,
  input  logic        fifoEmpty,
  output logic        fifoRdEn,
  output logic        serOut,
  output logic        serValid,
  output logic        byteStart,
  output logic [15:0] underflowCnt
);

  logic [BIT_CNT_W-1:0] bitCnt;
  logic [BYTE_W-1:0]    shreg;
  logic [BYTE_W-1:0]    nextByte;
  logic [BYTE_W-1:0]    holdByte;
  logic [15:0]          ufCnt;
  logic                 holdValid;
  logic                 take;
  logic                 strobe;
  logic                 boundary;
  logic                 dataSlot;
  logic                 ufInc;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  byte_fifo_prefetch #(
    .DATA_W(BYTE_W)
  ) u_prefetch (
    .clk      (clk),
    .reset    (reset),
    .clkEn    (clkEn),
    .enable   (enable),
    .take     (take),
    .holdValid(holdValid),
    .holdByte (holdByte),
    .fifoDout (fifoDout),
    .fifoEmpty(fifoEmpty),
    .fifoRdEn (fifoRdEn)
  );

  assign strobe   = clkEn & bitEn & enable;
  assign boundary = strobe & (bitCnt == '0);
  // A capture landing on the boundary cycle is not yet visible in holdValid, so fill wins.
  assign take     = boundary & dataSlot & holdValid;
  assign ufInc    = boundary & dataSlot & ~holdValid;

`ifdef SER_SYNC_INSERT_EN
  localparam int                FRAME_W    = $clog2(FRAME_BYTES + 1);
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(FRAME_BYTES);
  localparam logic [BYTE_W-1:0]  RESET_BYTE = SYNC_WORD[15:8];

  sync_phase_t        phase, phaseNxt;
  logic [FRAME_W-1:0] frameCnt, frameNxt;

  // frameCnt counts data/fill bytes loaded since the last sync word.
  always_comb begin
    nextByte = holdValid ? holdByte : FILL_BYTE;
    dataSlot = 1'b1;
    phaseNxt = S_DATA;
    frameNxt = frameCnt + 1'b1;
    case (phase)
      S_SYNC_HI: begin
        nextByte = SYNC_WORD[7:0];
        dataSlot = 1'b0;
        phaseNxt = S_SYNC_LO;
        frameNxt = '0;
      end
      S_SYNC_LO: begin
        frameNxt = FRAME_W'(1);
      end
      default: begin
        if (frameCnt == FRAME_LAST) begin
          nextByte = SYNC_WORD[15:8];
          dataSlot = 1'b0;
          phaseNxt = S_SYNC_HI;
          frameNxt = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase    <= S_SYNC_HI;
      frameCnt <= '0;
    end else if (boundary) begin
      phase    <= phaseNxt;
      frameCnt <= frameNxt;
    end
  end
`else
  localparam logic [BYTE_W-1:0] RESET_BYTE = FILL_BYTE;

  logic unusedFrameCfg;
  assign unusedFrameCfg = ^{SYNC_WORD, FRAME_BYTES};

  always_comb begin
    nextByte = holdValid ? holdByte : FILL_BYTE;
    dataSlot = 1'b1;
  end
`endif

  // Shifter stage: one bit per strobe, next byte loaded on the strobe that sends bit 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      bitCnt    <= '1;
      shreg     <= RESET_BYTE;
      serOut    <= 1'b0;
      serValid  <= 1'b0;
      byteStart <= 1'b0;
      ufCnt     <= '0;
    end else begin
      serValid  <= strobe;
      byteStart <= strobe & (bitCnt == '1);
      if (strobe) begin
        serOut <= shreg[bitCnt];
        bitCnt <= bitCnt - 1'b1;
        if (bitCnt == '0) shreg <= nextByte;
      end
      if (ufInc) ufCnt <= sat_inc(ufCnt);
    end
  end

  assign underflowCnt = ufCnt;

endmodule

// File: tb/tb_byte_fifo_serializer.sv
// Directed bench for byte_fifo_serializer with a small clkEn-qualified FIFO model.
// Build with SER_SYNC_INSERT_EN defined to exercise the sync-word framing instead.
module tb_byte_fifo_serializer;

`ifdef SER_SYNC_INSERT_EN
  localparam int TB_FRAME = 2;
`else
  localparam int TB_FRAME = 64;
`endif

  logic        clk = 1'b0;
  logic        reset, clkEn, enable, bitEn;
  logic [7:0]  fifoDout;
  logic        fifoEmpty, fifoRdEn, serOut, serValid, byteStart;
  logic [15:0] underflowCnt;

  always #5 clk = ~clk;

  byte_fifo_serializer #(
    .FRAME_BYTES(TB_FRAME)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .clkEn       (clkEn),
    .enable      (enable),
    .bitEn       (bitEn),
    .fifoDout    (fifoDout),
    .fifoEmpty   (fifoEmpty),
    .fifoRdEn    (fifoRdEn),
    .serOut      (serOut),
    .serValid    (serValid),
    .byteStart   (byteStart),
    .underflowCnt(underflowCnt)
  );

  // FIFO model: 64 deep, registered dout, everything qualified by clkEn.
  logic [7:0] mem [0:63];
  logic [5:0] wp, rp;
  logic [6:0] cnt;
  logic       fifoWr, fifoClr;
  logic [7:0] fifoDin;

  assign fifoEmpty = (cnt == 7'd0);

  always @(posedge clk) begin
    if (fifoClr) begin
      wp       <= '0;
      rp       <= '0;
      cnt      <= '0;
      fifoDout <= '0;
    end else if (clkEn) begin
      if (fifoWr) begin
        mem[wp] <= fifoDin;
        wp      <= wp + 6'd1;
      end
      if (fifoRdEn) rp <= rp + 6'd1;
      cnt      <= cnt + 7'(fifoWr) - 7'(fifoRdEn);
      fifoDout <= mem[rp];
    end
  end

  int         nChecks = 0, nErrors = 0;
  int         cyc = 0, bitPer = 1;
  bit         togg = 1'b0;
  logic [7:0] wq[$];
  logic [7:0] outQ[$];
  logic [7:0] cur = 8'h00;
  int         nb = 0, bsCnt = 0, pops = 0, rdViol = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, audit the pop strobe, then collect the registered outputs.
  task automatic step();
    cyc++;
    clkEn  = togg ? cyc[0] : 1'b1;
    bitEn  = ((cyc % bitPer) == 0);
    fifoWr = 1'b0;
    if (clkEn && wq.size() > 0) begin
      fifoWr  = 1'b1;
      fifoDin = wq.pop_front();
    end
    #2;
    if (fifoRdEn) begin
      pops++;
      if (!clkEn || fifoEmpty || !enable || reset) rdViol++;
    end
    @(posedge clk);
    #1;
    if (serValid) begin
      if (byteStart) begin
        nb = 0;
        bsCnt++;
      end
      cur = {cur[6:0], serOut};
      nb++;
      if (nb == 8) outQ.push_back(cur);
    end
  endtask

  task automatic clearMon();
    outQ.delete();
    nb    = 0;
    bsCnt = 0;
    pops  = 0;
  endtask

  task automatic doReset();
    reset   = 1'b1;
    enable  = 1'b0;
    togg    = 1'b0;
    fifoClr = 1'b1;
    wq.delete();
    step();
    step();
    reset   = 1'b0;
    fifoClr = 1'b0;
    clearMon();
  endtask

  task automatic waitBytes(input int n, input int maxCyc, input string tag);
    int i;
    i = 0;
    while (outQ.size() < n && i < maxCyc) begin
      step();
      i++;
    end
    check({tag, "_bytes"}, outQ.size(), n);
  endtask

`ifdef SER_SYNC_INSERT_EN
  logic [7:0] exp5 [0:7] = '{8'hEB, 8'h90, 8'h11, 8'h12, 8'hEB, 8'h90, 8'h13, 8'h14};
`endif

  initial begin
    reset   = 1'b1;
    enable  = 1'b0;
    clkEn   = 1'b1;
    bitEn   = 1'b0;
    fifoWr  = 1'b0;
    fifoDin = 8'h00;
    fifoClr = 1'b1;

    doReset();
    reset = 1'b1;
    step();
    check("rst_serValid", serValid, 0);
    check("rst_serOut", serOut, 0);
    check("rst_byteStart", byteStart, 0);
    check("rst_underflowCnt", underflowCnt, 0);
    check("rst_fifoRdEn", fifoRdEn, 0);

`ifdef SER_SYNC_INSERT_EN
    // Sync framing with FRAME_BYTES=2.
    doReset();
    for (int i = 0; i < 4; i++) wq.push_back(8'h11 + 8'(i));
    for (int i = 0; i < 8; i++) step();
    bitPer = 1;
    enable = 1'b1;
    waitBytes(8, 200, "t5");
    for (int i = 0; i < 8; i++) check($sformatf("t5_byte%0d", i), outQ[i], exp5[i]);
    check("t5_byteStarts", bsCnt, 8);
    check("t5_pops", pops, 4);
    check("t5_underflow", underflowCnt, 0);
`else
    // Two data bytes, bitEn every 4 clk.
    doReset();
    bitPer = 4;
    wq.push_back(8'hA5);
    wq.push_back(8'h3C);
    enable = 1'b1;
    waitBytes(3, 400, "t1a");
    check("t1_underflow", underflowCnt, 1);
    waitBytes(4, 200, "t1b");
    check("t1_byte0", outQ[0], 8'h55);
    check("t1_byte1", outQ[1], 8'hA5);
    check("t1_byte2", outQ[2], 8'h3C);
    check("t1_byte3", outQ[3], 8'h55);
    check("t1_pops", pops, 2);

    // Empty FIFO, bitEn every clk.
    doReset();
    bitPer = 1;
    enable = 1'b1;
    waitBytes(3, 100, "t2a");
    check("t2_underflow", underflowCnt, 3);
    waitBytes(4, 50, "t2b");
    for (int i = 0; i < 4; i++) check($sformatf("t2_byte%0d", i), outQ[i], 8'h55);
    check("t2_pops", pops, 0);

    // clkEn toggling, 64-byte burst.
    doReset();
    togg   = 1'b1;
    bitPer = 1;
    for (int i = 0; i < 64; i++) wq.push_back(8'(i));
    enable = 1'b1;
    waitBytes(65, 1500, "t3");
    check("t3_byte_fill", outQ[0], 8'h55);
    for (int i = 0; i < 64; i++) check($sformatf("t3_byte%0d", i + 1), outQ[i + 1], i);
    check("t3_pops", pops, 64);

    // Reset in the middle of byte 0x0F with 0xF0 held.
    doReset();
    bitPer = 4;
    wq.push_back(8'h0F);
    wq.push_back(8'hF0);
    wq.push_back(8'h77);
    enable = 1'b1;
    for (int i = 0; i < 300 && !(outQ.size() == 1 && nb == 4); i++) step();
    check("t4_mid_byte", nb, 4);
    check("t4_first_byte", outQ[0], 8'h55);
    reset = 1'b1;
    step();
    check("t4_rst_serValid", serValid, 0);
    check("t4_rst_byteStart", byteStart, 0);
    check("t4_rst_serOut", serOut, 0);
    check("t4_rst_underflow", underflowCnt, 0);
    reset = 1'b0;
    clearMon();
    waitBytes(2, 200, "t4");
    check("t4_restart_fill", outQ[0], 8'h55);
    check("t4_next_fifo", outQ[1], 8'h77);
    check("t4_pops", pops, 1);

    // Saturation: preset the counter near the top, then keep underrunning.
    doReset();
    bitPer = 1;
    force dut.ufCnt = 16'hFFFD;
    step();
    release dut.ufCnt;
    step();
    enable = 1'b1;
    waitBytes(2, 50, "t6a");
    check("t6_reach_max", underflowCnt, 16'hFFFF);
    waitBytes(5, 50, "t6b");
    check("t6_hold_max", underflowCnt, 16'hFFFF);
`endif

    check("rdEn_violations", rdViol, 0);
    $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
    $finish;
  end

endmodule
